// File: rtl/branch_predictor_pkg.sv
// Shared constants for the gshare branch predictor: counter states, default sizes
// and the beq/bne predecode encodings used by the IF-stage predecoder.
package branch_predictor_pkg;

  localparam int unsigned IDX_W_DEF  = 4;
  localparam int unsigned HIST_W_DEF = 4;

  typedef logic [1:0] cnt_t;

  localparam cnt_t SNT = 2'b00;
  localparam cnt_t WNT = 2'b01;
  localparam cnt_t WT  = 2'b10;
  localparam cnt_t ST  = 2'b11;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  // True for the conditional branches this predictor tracks.
  function automatic logic is_cond_branch(input logic [31:0] instr);
    return (instr[6:0] == OPC_BRANCH) &&
           ((instr[14:12] == F3_BEQ) || (instr[14:12] == F3_BNE));
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-value logic for a 2-bit saturating counter: steps toward ST on inc,
// toward SNT otherwise, holding at either end.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  cnt_t cnt,
  input  logic inc,
  output cnt_t next_cnt
);

  always_comb begin
    next_cnt = cnt;
    if (inc) begin
      if (cnt != ST) next_cnt = cnt + 2'd1;
    end else begin
      if (cnt != SNT) next_cnt = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// gshare direction predictor: combinational IF lookup, non-speculative training at EX.
// Define BP_PERF_CNT_EN to add the perf_br / perf_miss branch and mispredict counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned HIST_W   = HIST_W_DEF,
  parameter cnt_t        CNT_INIT = WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  input  logic             if_is_branch,
  output logic             predicted,
  output logic [IDX_W-1:0] if_idx,
  input  logic             ex_br_valid,
  input  logic [IDX_W-1:0] ex_idx,
  input  logic             ex_taken,
  input  logic             Wrong_prediction
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]      perf_br,
  output logic [31:0]      perf_miss
`endif
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  // History is folded into the index by XOR, so it may not be wider than it.
  if (HIST_W > IDX_W) begin : g_bad_hist_w
    $error("branch_predictor: HIST_W (%0d) must not exceed IDX_W (%0d)", HIST_W, IDX_W);
  end
  if (HIST_W < 1) begin : g_bad_hist_min
    $error("branch_predictor: HIST_W must be at least 1");
  end

  logic [HIST_W-1:0] ghr_q;
  logic [HIST_W-1:0] ghr_nxt;
  cnt_t              cnt_tbl [DEPTH];
  cnt_t              cnt_cur;
  cnt_t              cnt_nxt;

  // Lookup: no bypass from a same-cycle update; both table and history are pre-update.
  assign if_idx    = if_pc[IDX_W-1:0] ^ IDX_W'(ghr_q);
  assign predicted = if_is_branch & cnt_tbl[if_idx][1];

  if (HIST_W > 1) begin : g_ghr_shift
    assign ghr_nxt = {ghr_q[HIST_W-2:0], ex_taken};
  end else begin : g_ghr_bit
    assign ghr_nxt = ex_taken;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q <= '0;
    end else if (ex_br_valid) begin
      ghr_q <= ghr_nxt;
    end
  end

  assign cnt_cur = cnt_tbl[ex_idx];

  sat_counter2 u_sat_counter2 (
    .cnt      (cnt_cur),
    .inc      (ex_taken),
    .next_cnt (cnt_nxt)
  );

  // Training writes back to the entry that produced the prediction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        cnt_tbl[i] <= CNT_INIT;
      end
    end else if (ex_br_valid) begin
      cnt_tbl[ex_idx] <= cnt_nxt;
    end
  end

  // Upper PC bits never reach the index.
  logic unused_pc_hi;
  assign unused_pc_hi = ^if_pc[31:IDX_W];

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_count;
  logic [31:0] mispredict_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_count         <= '0;
      mispredict_count <= '0;
    end else if (ex_br_valid) begin
      br_count <= br_count + 32'd1;
      if (Wrong_prediction) mispredict_count <= mispredict_count + 32'd1;
    end
  end

  assign perf_br   = br_count;
  assign perf_miss = mispredict_count;
`else
  // Mispredict flag only feeds the optional statistics.
  logic unused_wrong;
  assign unused_wrong = Wrong_prediction;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected lookups are queued when driven and
// popped when the outputs are sampled; a small history model supplies the XOR term.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_is_branch;
  logic        predicted;
  logic [3:0]  if_idx;
  logic        ex_br_valid;
  logic [3:0]  ex_idx;
  logic        ex_taken;
  logic        Wrong_prediction;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_br;
  logic [31:0] perf_miss;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] ghr_m;
  logic       exp_pred_q [$];
  logic [3:0] exp_idx_q  [$];
  string      tag_q      [$];

  branch_predictor #(
    .IDX_W    (4),
    .HIST_W   (4),
    .CNT_INIT (WNT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_is_branch     (if_is_branch),
    .predicted        (predicted),
    .if_idx           (if_idx),
    .ex_br_valid      (ex_br_valid),
    .ex_idx           (ex_idx),
    .ex_taken         (ex_taken),
    .Wrong_prediction (Wrong_prediction)
`ifdef BP_PERF_CNT_EN
    ,
    .perf_br          (perf_br),
    .perf_miss        (perf_miss)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic pred, input logic [3:0] idx);
    tag_q.push_back(tag);
    exp_pred_q.push_back(pred);
    exp_idx_q.push_back(idx);
  endtask

  task automatic check_out();
    string      t;
    logic       ep;
    logic [3:0] ei;
    if (tag_q.size() == 0) begin
      chk("scoreboard_empty", 32'(tag_q.size()), 32'd1);
    end else begin
      t  = tag_q.pop_front();
      ep = exp_pred_q.pop_front();
      ei = exp_idx_q.pop_front();
      chk({t, "/predicted"}, 32'(predicted), 32'(ep));
      chk({t, "/if_idx"}, 32'(if_idx), 32'(ei));
    end
  endtask

  // Drive an IF lookup mid-cycle and sample before the next rising edge.
  task automatic lookup(input string tag, input logic [31:0] pc, input logic br, input logic pred);
    logic [3:0] pc_lo;
    @(negedge clk);
    if_pc        = pc;
    if_is_branch = br;
    pc_lo        = pc[3:0];
    push_exp(tag, pred, pc_lo ^ ghr_m);
    #1;
    check_out();
  endtask

  task automatic train(input logic [3:0] idx, input logic taken, input logic wrong);
    @(negedge clk);
    ex_br_valid      = 1'b1;
    ex_idx           = idx;
    ex_taken         = taken;
    Wrong_prediction = wrong;
    @(posedge clk);
    ghr_m = {ghr_m[2:0], taken};
    #1;
    ex_br_valid      = 1'b0;
    Wrong_prediction = 1'b0;
  endtask

  // Four not-taken resolutions on index 0 bring the history back to zero.
  task automatic flush_ghr();
    repeat (4) train(4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b0;
    if_pc            = 32'd5;
    if_is_branch     = 1'b1;
    ex_br_valid      = 1'b0;
    ex_idx           = 4'd0;
    ex_taken         = 1'b0;
    Wrong_prediction = 1'b0;
    ghr_m            = 4'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    push_exp("reset_hold", 1'b0, 4'd5);
    #1;
    check_out();
    @(negedge clk);
    rst = 1'b1;

    // Inputs without ex_br_valid must not touch state.
    @(negedge clk);
    ex_taken = 1'b1;
    ex_idx = 4'd5;
    Wrong_prediction = 1'b1;
    repeat (2) @(posedge clk);
    lookup("idle_ignored", 32'd5, 1'b1, 1'b0);
    Wrong_prediction = 1'b0;

    // Train index 5 up to strongly taken.
    train(4'd5, 1'b1, 1'b0);
    flush_ghr();
    train(4'd5, 1'b1, 1'b0);
    flush_ghr();
    lookup("trained_taken", 32'd5, 1'b1, 1'b1);
    lookup("not_branch", 32'd5, 1'b0, 1'b0);

    // Saturation high: extra increments then one decrement must still predict taken.
    repeat (3) train(4'd5, 1'b1, 1'b0);
    train(4'd5, 1'b0, 1'b0);
    flush_ghr();
    lookup("sat_high", 32'd5, 1'b1, 1'b1);
    train(4'd5, 1'b0, 1'b0);
    lookup("dec_to_wnt", 32'd5, 1'b1, 1'b0);

    // Saturation low on index 3.
    repeat (4) train(4'd3, 1'b0, 1'b0);
    train(4'd3, 1'b1, 1'b0);
    lookup("sat_low_inc", 32'd2, 1'b1, 1'b0);
    train(4'd3, 1'b1, 1'b0);
    lookup("sat_low_wt", 32'd0, 1'b1, 1'b1);

    // History hashing: taken 1,0,1 gives GHR 0101.
    flush_ghr();
    train(4'd10, 1'b1, 1'b0);
    train(4'd10, 1'b0, 1'b0);
    train(4'd10, 1'b1, 1'b0);
    lookup("hist_hash", 32'h0000000C, 1'b1, 1'b0);
    chk("hist_hash_idx_const", 32'(if_idx), 32'h9);

    // Same-cycle lookup and training of index 7: pre-update value is seen.
    @(negedge clk);
    if_pc = 32'd2;
    if_is_branch = 1'b1;
    ex_br_valid = 1'b1;
    ex_idx = 4'd7;
    ex_taken = 1'b1;
    push_exp("hazard_same", 1'b0, 4'd7);
    #1;
    check_out();
    @(posedge clk);
    ghr_m = {ghr_m[2:0], 1'b1};
    #1;
    ex_br_valid = 1'b0;
    lookup("hazard_next", 32'h0000000C, 1'b1, 1'b1);
    chk("hazard_next_idx_const", 32'(if_idx), 32'h7);

    // Asynchronous reset between edges with an update pending.
    @(negedge clk);
    ex_br_valid = 1'b1;
    ex_idx = 4'd3;
    ex_taken = 1'b1;
    if_pc = 32'd3;
    if_is_branch = 1'b1;
    #2;
    rst = 1'b0;
    ghr_m = 4'd0;
    #1;
    push_exp("async_rst", 1'b0, 4'd3);
    check_out();
`ifdef BP_PERF_CNT_EN
    chk("async_rst/perf_br", perf_br, 32'd0);
    chk("async_rst/perf_miss", perf_miss, 32'd0);
`endif
    @(posedge clk);
    #1;
    ex_br_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    lookup("after_rst_idx3", 32'd3, 1'b1, 1'b0);
    lookup("after_rst_idx7", 32'd7, 1'b1, 1'b0);

    // Ten resolutions, three flagged as mispredicts.
    for (int i = 0; i < 10; i++) begin
      train(4'd12, 1'(i % 2), (i == 1) || (i == 4) || (i == 8));
    end
`ifdef BP_PERF_CNT_EN
    #1;
    chk("perf_br", perf_br, 32'd10);
    chk("perf_miss", perf_miss, 32'd3);
`endif
    lookup("post_perf", 32'd12, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direction predictor feeding the `predicted` bit that the EX stage checks against its resolved branch decision.
- Closes the loop on `Wrong_prediction`: trains a gshare table of 2-bit saturating counters from EX resolution results.
- Lookup in IF is combinational; training happens on the clock edge when EX resolves a conditional branch (beq/bne).
- The lookup index travels down the pipeline with the instruction, so training hits the entry that made the prediction.

Parameters:
- IDX_W, 4, index width; table holds 2^IDX_W counters.
- HIST_W, 4, global history register width (HIST_W <= IDX_W).
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_pc  in  32  PC of the instruction in IF (word address).
- if_is_branch  in  1  IF instruction is beq/bne (predecoded).
- predicted  out  1  predicted taken; 0 whenever if_is_branch=0.
- if_idx  out  IDX_W  lookup index; pipelined alongside the instruction to EX.
- ex_br_valid  in  1  EX holds a resolved beq/bne this cycle.
- ex_idx  in  IDX_W  index carried from IF for that branch.
- ex_taken  in  1  resolved BranchDecision.
- Wrong_prediction  in  1  EX mispredict flag; only meaningful when ex_br_valid=1.

Behaviour:
- Index generation:
  - if_idx = if_pc[IDX_W-1:0] XOR {zero-extend GHR to IDX_W}.
  - predicted = if_is_branch & table[if_idx][1].
  - Both outputs are purely combinational from if_pc and current state (0-cycle latency).
- Counter update, on posedge clk when ex_br_valid=1:
  - table[ex_idx] increments if ex_taken=1, decrements otherwise.
  - Saturates at 2'b11 and 2'b00; no wrap-around.
- GHR update, same edge: GHR <= {GHR[HIST_W-2:0], ex_taken}.
  - GHR is non-speculative and updated only at resolution.
- When ex_br_valid=0, no state changes. Wrong_prediction and ex_taken are ignored.
- Simultaneous lookup and training of the same index in one cycle:
  - The lookup returns the pre-update value; there is no bypass.
  - The GHR used by if_idx is also pre-update.
- Wrong_prediction does not alter the update rule. It is consumed only by the optional stats logic.
- Reset (rst=0, asynchronous):
  - every table entry <= CNT_INIT; GHR <= 0; stats counters <= 0.
  - Outputs are therefore predicted=0 and if_idx=if_pc[IDX_W-1:0].
- Reset asserted mid-operation:
  - An update in flight on that edge is discarded.
  - State is cleared immediately, not at the next edge.
- Out-of-range widths: HIST_W > IDX_W is illegal and is checked by an elaboration-time error.

Optional Feature:
- Macro: BP_PERF_CNT_EN.
- When defined:
  - Adds 32-bit counters br_count and mispredict_count, exposed as outputs perf_br[31:0] and perf_miss[31:0].
  - br_count increments on each ex_br_valid cycle.
  - mispredict_count increments when ex_br_valid & Wrong_prediction.
  - Both wrap at 2^32 and reset to 0.
- When undefined: those ports and registers do not exist, and prediction behaviour is identical.

Decomposition:
- Shared package/include:
  - counter-state constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - the defaults for IDX_W and HIST_W.
  - the opcode encodings already used for beq/bne predecode.
- One sub-module, sat_counter2: next-value logic for a 2-bit saturating counter (inc/dec in, 2-bit out).
- The table is an array of registers in the top level.

Test Plan:
- Reset: hold rst=0, then release; if_pc=5, if_is_branch=1 -> predicted=0, if_idx=5.
- Training:
  - 2 taken updates at ex_idx=5 (GHR reset back to 0 between them) -> counter 01->10->11.
  - Then if_pc=5 with GHR=0 -> predicted=1.
  - 3 more taken updates -> counter stays 11.
- Saturation low: 4 not-taken updates on index 3 -> counter 00; 1 taken -> 01, predicted still 0.
- History hashing: ex_taken sequence 1,0,1 -> GHR=4'b0101; if_pc=32'h0000000C -> if_idx=4'b1001.
- Same-cycle hazard: if_pc maps to idx 7 (counter 01) while a taken update hits idx 7 -> predicted=0 that cycle, 1 the next cycle at the same GHR-adjusted PC.
- Async reset mid-update: drop rst low between edges with ex_br_valid=1 -> table, GHR and perf counters are 0/CNT_INIT before the next edge.
- With BP_PERF_CNT_EN defined: 10 branches with 3 mispredicts -> perf_br=10, perf_miss=3.
